digit_game_core: RTL
====================

// Module: digit_game_core
// PURPOSE
//  Parametrised game core: menu FSM plus NUM_CH modulo-MODULO digit counters with cursor-based editing.
//  Generalises the fixed 10x4-bit status logic: channel count, digit width and modulus are parameters.
//  Adds active-channel selection, cursor wrap, sticky per-channel wrap flags and a buzzer request pulse.
//  Sits between mat_key (debounced single-cycle key pulses) and the buzzer/display logic in top.
// PARAMETERS
//  NUM_CH     10  number of digit channels (1..16)
//  DIGIT_W    4   bits per digit
//  MODULO     10  digit modulus; 2 <= MODULO <= 2**DIGIT_W
//  RST_DIGIT  1   reset/entry value of every digit; must be < MODULO
//  TICK_DIV   50_000_000  auto-tick period in clk cycles (DGC_AUTO_TICK_EN only)
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 synchronous reset, active-high
//  key_up      in   1                 1-cycle pulse: increment digit under cursor
//  key_down    in   1                 1-cycle pulse: decrement digit under cursor
//  key_left    in   1                 1-cycle pulse: cursor -1
//  key_right   in   1                 1-cycle pulse: cursor +1
//  key_ok      in   1                 1-cycle pulse: confirm / advance menu
//  key_back    in   1                 1-cycle pulse: exit to IDLE
//  key_help    in   1                 1-cycle pulse: IDLE -> HELP
//  key_count   in   1                 1-cycle pulse: step active channel count in SELECT
//  state       out  2                 IDLE=0, HELP=1, SELECT=2, PLAY=3
//  active_cnt  out  $clog2(NUM_CH+1)  channels in play, 1..NUM_CH
//  cursor      out  $clog2(NUM_CH)    selected channel, 0..active_cnt-1 (width min 1)
//  status      out  NUM_CH*DIGIT_W    packed digits, channel i at [i*DIGIT_W +: DIGIT_W]
//  wrap_flag   out  NUM_CH            sticky: channel wrapped MODULO-1 -> 0 since PLAY entry
//  buzz_req    out  1                 1-cycle pulse on any wrap event
// BEHAVIOUR
//  Reset: state=IDLE, active_cnt=1, cursor=0, all digits=RST_DIGIT, wrap_flag=0, buzz_req=0.
//  All outputs registered; key effect visible the cycle after the pulse (latency 1).
//  Key priority in one cycle: key_back > key_ok > key_help > key_count.
//  IDLE: help->HELP; ok->SELECT.  HELP: back->IDLE; ok->SELECT.
//  SELECT: count -> active_cnt+1, NUM_CH wraps to 1; ok->PLAY; back->IDLE.
//  SELECT->PLAY: cursor=0, wrap_flag=0, active digits reload RST_DIGIT.
//  PLAY: back->IDLE (digits, flags, active_cnt retained); ok ignored.
//  PLAY cursor: right at active_cnt-1 -> 0; left at 0 -> active_cnt-1; left+right same cycle: no move.
//  PLAY digit: up: d+1, MODULO-1 -> 0 sets wrap_flag[cursor] and buzz_req; down: d-1, 0 -> MODULO-1,
//   no flag. up+down same cycle: no change. Edit + move same cycle: edit uses old cursor.
//  Channels >= active_cnt never change in PLAY; up/down/left/right ignored outside PLAY.
//  buzz_req is high exactly one cycle per cycle containing >=1 wrap; no queueing.
//  rst mid-PLAY: everything returns to reset values next edge; prescaler cleared.
// CONFIGURATION
//  DGC_AUTO_TICK_EN defined: prescaler counts clk in PLAY only, cleared on PLAY entry; every TICK_DIV
//   cycles each active channel increments with wrap/flag/buzz rules as key_up. Tick and key_up on
//   same channel same cycle: single increment. Tick + key_down same channel: no change.
//  Undefined: no prescaler, TICK_DIV unused, digits change only by keys.
// STRUCTURE
//  Package dgc_pkg: state_t enum (IDLE/HELP/SELECT/PLAY), clog2-derived width constants.
//  Sub-module dgc_channel (generate x NUM_CH): one digit with load/inc/dec inputs, outputs value and
//   wrap pulse; core ORs channel wrap pulses into buzz_req.
// TESTING
//  1 rst=1 two cycles -> state=0, active_cnt=1, status=0x1111111111, wrap_flag=0, buzz_req=0.
//  2 ok, count x3, ok -> state=3, active_cnt=4, cursor=0; count x10 in SELECT from 1 -> back to 1.
//  3 PLAY, digit0=9, up -> digit0=0, wrap_flag[0]=1, buzz_req high exactly 1 cycle.
//  4 digit0=0, down -> digit0=9, wrap_flag unchanged, buzz_req=0; up+down together -> no change.
//  5 active_cnt=3: right x3 from 0 -> 1,2,0; left from 0 -> 2; up on ch5 never alters status[23:20].
//  6 DGC_AUTO_TICK_EN, TICK_DIV=4, active_cnt=2 -> both digits +1 every 4 cycles; tick+up ch0 -> +1 only.

Source files
------------

// File: rtl/dgc_pkg.sv
// Shared types and width helpers for the digit game core.
package dgc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELP   = 2'd1;
  localparam logic [1:0] ST_SELECT = 2'd2;
  localparam logic [1:0] ST_PLAY   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    HELP   = ST_HELP,
    SELECT = ST_SELECT,
    PLAY   = ST_PLAY
  } state_t;

  // Width of a count that must hold 1..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index 0..n-1, never narrower than one bit.
  function automatic int cur_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dgc_channel.sv
// One modulo-MODULO digit with reload, increment and decrement; wrap is a
// combinational pulse for the edge on which the digit rolls MODULO-1 -> 0.
module dgc_channel #(
  parameter int DIGIT_W   = 4,
  parameter int MODULO    = 10,
  parameter int RST_DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] value,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULO - 1);
  localparam logic [DIGIT_W-1:0] RST_V = DIGIT_W'(RST_DIGIT);

  logic [DIGIT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    wrap    = 1'b0;
    if (load) begin
      value_d = RST_V;
    end else if (inc && !dec) begin
      if (value_q == MAX_V) begin
        value_d = '0;
        wrap    = 1'b1;
      end else begin
        value_d = value_q + DIGIT_W'(1);
      end
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? MAX_V : value_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= RST_V;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/digit_game_core.sv
// Menu FSM plus NUM_CH cursor-edited digit channels with sticky wrap flags.
// Optional auto-tick prescaler enabled by defining DGC_AUTO_TICK_EN.
//
// state  | meaning
// IDLE   | menu idle, waits for help or ok
// HELP   | help screen, ok starts selection, back returns
// SELECT | key_count steps active channel count, ok starts play
// PLAY   | cursor moves and digit edits on active channels
module digit_game_core
  import dgc_pkg::*;
#(
  parameter int NUM_CH    = 10,
  parameter int DIGIT_W   = 4,
  parameter int MODULO    = 10,
  parameter int RST_DIGIT = 1,
  parameter int TICK_DIV  = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_up,
  input  logic                        key_down,
  input  logic                        key_left,
  input  logic                        key_right,
  input  logic                        key_ok,
  input  logic                        key_back,
  input  logic                        key_help,
  input  logic                        key_count,
  output logic [1:0]                  state,
  output logic [cnt_w(NUM_CH)-1:0]    active_cnt,
  output logic [cur_w(NUM_CH)-1:0]    cursor,
  output logic [NUM_CH*DIGIT_W-1:0]   status,
  output logic [NUM_CH-1:0]           wrap_flag,
  output logic                        buzz_req
);

  localparam int CNT_W = cnt_w(NUM_CH);
  localparam int CUR_W = cur_w(NUM_CH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   active_cnt_q, active_cnt_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  logic [NUM_CH-1:0]  wrap_flag_q, wrap_flag_d;
  logic               buzz_req_q, buzz_req_d;

  logic               enter_play, play_edit, tick;
  logic [CNT_W-1:0]   cur_ext, last_idx;
  logic [NUM_CH-1:0]  ch_load, ch_inc, ch_dec, ch_wrap;

  assign enter_play = (state_q == SELECT) && !key_back && key_ok;
  assign play_edit  = (state_q == PLAY) && !key_back;
  assign cur_ext    = CNT_W'(cursor_q);
  assign last_idx   = active_cnt_q - CNT_W'(1);

  // Single-winner priority: back > ok > help > count.
  always_comb begin
    state_d      = state_q;
    active_cnt_d = active_cnt_q;
    case (state_q)
      IDLE: begin
        if (!key_back) begin
          if (key_ok)        state_d = SELECT;
          else if (key_help) state_d = HELP;
        end
      end
      HELP: begin
        if (key_back)    state_d = IDLE;
        else if (key_ok) state_d = SELECT;
      end
      SELECT: begin
        if (key_back)    state_d = IDLE;
        else if (key_ok) state_d = PLAY;
        else if (!key_help && key_count)
          active_cnt_d = (active_cnt_q == CNT_W'(NUM_CH)) ? CNT_W'(1)
                                                          : active_cnt_q + CNT_W'(1);
      end
      PLAY: begin
        if (key_back) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cursor_d = cursor_q;
    if (enter_play) begin
      cursor_d = '0;
    end else if (play_edit && key_right && !key_left) begin
      cursor_d = (cur_ext == last_idx) ? '0 : CUR_W'(cur_ext + CNT_W'(1));
    end else if (play_edit && key_left && !key_right) begin
      cursor_d = (cursor_q == '0) ? CUR_W'(last_idx) : cursor_q - CUR_W'(1);
    end
  end

  always_comb begin
    wrap_flag_d = enter_play ? '0 : (wrap_flag_q | ch_wrap);
    buzz_req_d  = |ch_wrap;
  end

`ifdef DGC_AUTO_TICK_EN
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;

  // Down-counter reloaded on PLAY entry; terminal count fires one tick.
  always_comb begin
    presc_d = presc_q;
    if (enter_play)     presc_d = PRE_LOAD;
    else if (play_edit) presc_d = (presc_q == '0) ? PRE_LOAD : presc_q - PRE_W'(1);
  end

  assign tick = play_edit && (presc_q == '0);

  always_ff @(posedge clk) begin
    if (rst) presc_q <= PRE_LOAD;
    else     presc_q <= presc_d;
  end
`else
  assign tick = 1'b0 && (TICK_DIV > 0);
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic active, sel;
    assign active     = active_cnt_q > CNT_W'(i);
    assign sel        = play_edit && active && (cursor_q == CUR_W'(i));
    assign ch_load[i] = enter_play && active;
    // A tick merges with key_up; key_down against a tick cancels it.
    assign ch_inc[i]  = (sel && key_up && !key_down) || (tick && active);
    assign ch_dec[i]  = sel && key_down && !key_up;

    dgc_channel #(
      .DIGIT_W   (DIGIT_W),
      .MODULO    (MODULO),
      .RST_DIGIT (RST_DIGIT)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (ch_load[i]),
      .inc   (ch_inc[i]),
      .dec   (ch_dec[i]),
      .value (status[i*DIGIT_W +: DIGIT_W]),
      .wrap  (ch_wrap[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_cnt_q <= CNT_W'(1);
      cursor_q     <= '0;
      wrap_flag_q  <= '0;
      buzz_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_cnt_q <= active_cnt_d;
      cursor_q     <= cursor_d;
      wrap_flag_q  <= wrap_flag_d;
      buzz_req_q   <= buzz_req_d;
    end
  end

  assign state      = state_q;
  assign active_cnt = active_cnt_q;
  assign cursor     = cursor_q;
  assign wrap_flag  = wrap_flag_q;
  assign buzz_req   = buzz_req_q;

endmodule
